fifo_seq_ctrl: RTL
==================

// Module: fifo_seq_ctrl
// PURPOSE
//  Sequencer/arbiter for the 8 x 32-bit SCSI DMA FIFO. Shares FIFO access between the
//  SCSI state machine (byte side) and the CPU/bus state machine (longword side).
//  Generates the FIFO load/pointer strobes (LBYTE_, LLWORD, LHWORD, INCBO, INCNI, INCNO).
//  Owns the fill count, byte pointer and FULL/EMPTY flags. Single clock domain; sits
//  between both state machines and the FIFO datapath.
// PARAMETERS
//  DEPTH  8  FIFO depth in longwords; FIFO_CNT counts 0..DEPTH
//  CNT_W  4  width of FIFO_CNT; must hold DEPTH
// PORTS
//  CLK         in   1      system clock, all logic on rising edge
//  RST         in   1      synchronous reset, active high
//  DMADIR      in   1      1 = SCSI->memory (bytes in, longwords out); 0 = memory->SCSI
//  ACR_WR      in   1      1-cycle pulse: load start byte offset from ACR_A
//  ACR_A       in   2      ACR address bits 1:0 (start byte within longword)
//  FLUSH       in   1      level: push partial longword into FIFO (DMADIR=1 only)
//  FLUSH_DONE  out  1      1-cycle pulse: flush complete
//  SCSI_REQ    in   1      level: byte transfer request from SCSI SM
//  SCSI_ACK    out  1      1-cycle pulse: byte transfer granted/done
//  HOST_REQ    in   1      level: longword transfer request from CPU SM
//  HOST_ACK    out  1      1-cycle pulse: longword transfer granted/done
//  LBYTE_      out  1      active-low byte load strobe (DMADIR=1 byte writes)
//  LLWORD      out  1      load lower word strobe
//  LHWORD      out  1      load upper word strobe
//  INCBO       out  1      byte pointer increment strobe
//  INCNI       out  1      next-in (write pointer) increment
//  INCNO       out  1      next-out (read pointer) increment
//  BO          out  2      byte pointer; 3 = first byte, counts down to 0 = last byte
//  FIFO_CNT    out  CNT_W  longwords held
//  FIFOFULL    out  1      FIFO_CNT == DEPTH
//  FIFOEMPTY   out  1      FIFO_CNT == 0
// BEHAVIOUR
//  Reset: BO=3, FIFO_CNT=0, FIFOEMPTY=1, LBYTE_=1, state IDLE, last-served=HOST.
//   All other outputs 0. RST mid-transfer aborts the grant; no strobe that cycle.
//  FSM states IDLE, BYTE, WORD, FLSH. All strobes/ACKs are registered; they assert only
//   in the cycle the FSM is in the grant state (one cycle), then FSM returns to IDLE.
//   Request sampled in IDLE -> strobe+ACK next cycle. Max one transfer per 2 cycles.
//  Requesters drop REQ the cycle after ACK; REQ still high in IDLE is a new request.
//  IDLE priority: ACR_WR > FLUSH > SCSI/HOST arbitration.
//   ACR_WR in IDLE: BO <= 3 - ACR_A. ACR_WR outside IDLE is ignored.
//  Eligibility:
//   DMADIR=1: SCSI eligible only if !FIFOFULL; HOST eligible only if !FIFOEMPTY.
//   DMADIR=0: HOST eligible only if !FIFOFULL; SCSI eligible only if !FIFOEMPTY.
//  Arbitration: both eligible -> serve the side not served last (round robin).
//   Update last-served on each grant.
//  BYTE, DMADIR=1: LBYTE_=0, INCBO=1, SCSI_ACK=1, BO <= BO-1 (mod 4).
//   If BO==0: also INCNI=1 and FIFO_CNT+1.
//  BYTE, DMADIR=0: INCBO=1, SCSI_ACK=1, BO <= BO-1.
//   If BO==0: also INCNO=1 and FIFO_CNT-1.
//  WORD, DMADIR=1: INCNO=1, HOST_ACK=1, FIFO_CNT-1.
//  WORD, DMADIR=0: LLWORD=1, LHWORD=1, INCNI=1, HOST_ACK=1, FIFO_CNT+1.
//  FLUSH (DMADIR=1 only):
//   BO==3 -> FLUSH_DONE next cycle, no strobes.
//   BO!=3 and !FIFOFULL -> FLSH: INCNI=1, FIFO_CNT+1, BO <= 3, FLUSH_DONE=1.
//   BO!=3 and FIFOFULL -> stay IDLE, waiting on HOST grants (FLUSH keeps priority).
//   FLUSH with DMADIR=0 -> FLUSH_DONE next cycle, no strobes.
//  INCNI and INCNO are never asserted in the same cycle, so FIFO_CNT changes by +/-1 max.
//   FIFO_CNT never exceeds DEPTH or goes below 0; assertion required in RTL.
//  FIFOFULL/FIFOEMPTY are decoded from registered FIFO_CNT (same cycle as count).
//  DMADIR must be stable while FSM is not IDLE; changing it in IDLE is legal.
// TESTING
//  1. RST=1 for 1 cycle -> BO=3, FIFO_CNT=0, FIFOEMPTY=1, LBYTE_=1, all strobes 0.
//  2. DMADIR=1, 4 SCSI_REQ -> LBYTE_ low x4, BO 3,2,1,0,3; INCNI once on 4th; FIFO_CNT=1.
//  3. DMADIR=1, 32 bytes in -> FIFOFULL=1; 33rd SCSI_REQ gets no ACK until HOST_REQ
//     -> INCNO, FIFO_CNT=7.
//  4. SCSI_REQ and HOST_REQ held together with FIFO_CNT=4 -> ACKs alternate S,H,S,H...
//     (last-served=HOST after reset, so SCSI first).
//  5. ACR_WR with ACR_A=2 -> BO=1; 2 bytes in, then FLUSH -> INCNI on 2nd byte
//     (BO was 0), FLUSH_DONE with no strobe.
//  6. DMADIR=0: 1 HOST_REQ -> LLWORD=LHWORD=INCNI=1, FIFO_CNT=1; 4 SCSI_REQ
//     -> INCNO on 4th, FIFOEMPTY=1. RST asserted during WORD -> no ACK, FIFO_CNT=0.

Source files
------------

// File: rtl/fifo_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_seq_ctrl
// Purpose  : Arbitrates SCSI byte and host longword access to the 8 x 32-bit
//            DMA FIFO; owns fill count, byte pointer and FIFO load strobes.
// Revision : 1.0
// ============================================================================
module fifo_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_dmadir,
  input  logic             i_acr_wr,
  input  logic [1:0]       i_acr_a,
  input  logic             i_flush,
  output logic             o_flush_done,
  input  logic             i_scsi_req,
  output logic             o_scsi_ack,
  input  logic             i_host_req,
  output logic             o_host_ack,
  output logic             o_lbyte_n,
  output logic             o_llword,
  output logic             o_lhword,
  output logic             o_incbo,
  output logic             o_incni,
  output logic             o_incno,
  output logic [1:0]       o_bo,
  output logic [CNT_W-1:0] o_fifo_cnt,
  output logic             o_fifofull,
  output logic             o_fifoempty
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BYTE = 2'd1;
  localparam logic [1:0] S_WORD = 2'd2;
  localparam logic [1:0] S_FLSH = 2'd3;

  localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

  logic [1:0]       r_state;
  logic [1:0]       r_bo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_host;
  logic             r_lbyte_n;
  logic             r_llword;
  logic             r_lhword;
  logic             r_incbo;
  logic             r_incni;
  logic             r_incno;
  logic             r_scsi_ack;
  logic             r_host_ack;
  logic             r_flush_done;

  logic w_full;
  logic w_empty;
  logic w_scsi_ok;
  logic w_host_ok;
  logic w_pick_scsi;
  logic w_pick_host;
  logic w_flush_go;

  assign w_full      = (r_cnt == c_full);
  assign w_empty     = (r_cnt == '0);
  assign w_scsi_ok   = i_scsi_req && (i_dmadir ? !w_full  : !w_empty);
  assign w_host_ok   = i_host_req && (i_dmadir ? !w_empty : !w_full);
  assign w_pick_scsi = w_scsi_ok && (!w_host_ok || r_last_host);
  assign w_pick_host = w_host_ok && !w_pick_scsi;
  // A partial longword cannot be pushed into a full FIFO; the host drains it first.
  assign w_flush_go  = i_flush && (!i_dmadir || (r_bo == 2'd3) || !w_full);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_bo         <= 2'd3;
      r_cnt        <= '0;
      r_last_host  <= 1'b1;
      r_lbyte_n    <= 1'b1;
      r_llword     <= 1'b0;
      r_lhword     <= 1'b0;
      r_incbo      <= 1'b0;
      r_incni      <= 1'b0;
      r_incno      <= 1'b0;
      r_scsi_ack   <= 1'b0;
      r_host_ack   <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_lbyte_n    <= 1'b1;
      r_llword     <= 1'b0;
      r_lhword     <= 1'b0;
      r_incbo      <= 1'b0;
      r_incni      <= 1'b0;
      r_incno      <= 1'b0;
      r_scsi_ack   <= 1'b0;
      r_host_ack   <= 1'b0;
      r_flush_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_acr_wr) begin
            r_bo <= 2'd3 - i_acr_a;
          end else if (w_flush_go) begin
            r_state      <= S_FLSH;
            r_flush_done <= 1'b1;
            r_incni      <= i_dmadir && (r_bo != 2'd3);
          end else if (w_pick_scsi) begin
            r_state     <= S_BYTE;
            r_last_host <= 1'b0;
            r_scsi_ack  <= 1'b1;
            r_incbo     <= 1'b1;
            r_lbyte_n   <= !i_dmadir;
            r_incni     <= i_dmadir && (r_bo == 2'd0);
            r_incno     <= !i_dmadir && (r_bo == 2'd0);
          end else if (w_pick_host) begin
            r_state     <= S_WORD;
            r_last_host <= 1'b1;
            r_host_ack  <= 1'b1;
            r_incno     <= i_dmadir;
            r_incni     <= !i_dmadir;
            r_llword    <= !i_dmadir;
            r_lhword    <= !i_dmadir;
          end
        end
        default: begin
          // Counters follow the strobes at the end of the grant cycle.
          r_state <= S_IDLE;
          if (r_incni) begin
            r_cnt <= r_cnt + 1'b1;
          end else if (r_incno) begin
            r_cnt <= r_cnt - 1'b1;
          end
          if (r_incbo) begin
            r_bo <= r_bo - 2'd1;
          end else if ((r_state == S_FLSH) && r_incni) begin
            r_bo <= 2'd3;
          end
        end
      endcase
    end
  end

  always @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(r_incni && r_incno));
      assert (!(r_incni && (r_cnt == c_full)));
      assert (!(r_incno && (r_cnt == '0)));
      assert (r_cnt <= c_full);
    end
  end

  assign o_bo         = r_bo;
  assign o_fifo_cnt   = r_cnt;
  assign o_fifofull   = w_full;
  assign o_fifoempty  = w_empty;
  assign o_lbyte_n    = r_lbyte_n;
  assign o_llword     = r_llword;
  assign o_lhword     = r_lhword;
  assign o_incbo      = r_incbo;
  assign o_incni      = r_incni;
  assign o_incno      = r_incno;
  assign o_scsi_ack   = r_scsi_ack;
  assign o_host_ack   = r_host_ack;
  assign o_flush_done = r_flush_done;

endmodule
`default_nettype wire
